// File: rtl/multicycle_ctrl.sv
// Sequencing controller for a multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/mem/writeback, decodes datapath controls, counts retirements, traps on faults.
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem2reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_control,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       err_code
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_FUNCT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Wait counter only needs to reach MEM_TIMEOUT-1; it saturates so a disabled timeout never wraps.
    localparam int               WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic             TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] op;
        case (f)
            6'b100000: op = ALU_ADD;
            6'b100010: op = ALU_SUB;
            6'b100100: op = ALU_AND;
            6'b100101: op = ALU_OR;
            6'b101010: op = ALU_SLT;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t            state_r, state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  instr_count_r;
    logic [1:0]        err_code_r, err_next_s;
    logic              retire_s, timeout_hit_s, is_wait_s;

    logic pc_en_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
    logic reg_dst_s, mem2reg_s, reg_write_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, pc_src_s;
    logic [2:0] alu_control_s;

    assign timeout_hit_s = TIMEOUT_EN & ~mem_ready & (wait_cnt_r == WAIT_LAST);
    assign is_wait_s     = (state_r == S_FETCH) | (state_r == S_MEMRD) | (state_r == S_MEMWR);

    // Next-state, trap cause and retire decision.
    always_comb begin
        state_next_s = state_r;
        err_next_s   = err_code_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else if (timeout_hit_s) begin
                    state_next_s = S_TRAP;
                    err_next_s   = ERR_TIMEOUT;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_EXECUTE;
                    OP_BEQ:       state_next_s = S_BRANCH;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JUMP;
                    default: begin
                        state_next_s = S_TRAP;
                        err_next_s   = ERR_OPCODE;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (timeout_hit_s) begin
                    state_next_s = S_TRAP;
                    err_next_s   = ERR_TIMEOUT;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                    retire_s     = 1'b1;
                end else if (timeout_hit_s) begin
                    state_next_s = S_TRAP;
                    err_next_s   = ERR_TIMEOUT;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                if (funct_legal(funct)) begin
                    state_next_s = S_ALUWB;
                end else begin
                    state_next_s = S_TRAP;
                    err_next_s   = ERR_FUNCT;
                end
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_ADDIEX: state_next_s = S_ADDIWB;
            S_TRAP:   state_next_s = S_TRAP;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // State, wait counter, retire counter and sticky error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= '0;
            instr_count_r <= '0;
            err_code_r    <= 2'b00;
        end else begin
            state_r    <= state_next_s;
            err_code_r <= err_next_s;
            if (retire_s) begin
                instr_count_r <= instr_count_r + CNT_W'(1);
            end else begin
                instr_count_r <= instr_count_r;
            end
            if (state_next_s != state_r) begin
                wait_cnt_r <= '0;
            end else if (is_wait_s && !mem_ready && (wait_cnt_r != WAIT_MAX)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        pc_en_s       = 1'b0;
        iord_s        = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        reg_dst_s     = 1'b0;
        mem2reg_s     = 1'b0;
        reg_write_s   = 1'b0;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        pc_src_s      = 2'b00;
        alu_control_s = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready;
                pc_en_s     = mem_ready;
            end
            S_DECODE:  alu_src_b_s = 2'b11;
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                iord_s     = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEMWB: begin
                mem2reg_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_s   = 1'b1;
                alu_control_s = funct_alu(funct);
            end
            S_ALUWB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s   = 1'b1;
                alu_control_s = ALU_SUB;
                pc_src_s      = 2'b01;
                pc_en_s       = zero;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDIWB:  reg_write_s = 1'b1;
            S_JUMP: begin
                pc_src_s = 2'b10;
                pc_en_s  = 1'b1;
            end
            S_TRAP:    pc_en_s = 1'b0;
            default:   pc_en_s = 1'b0;
        endcase
    end

    // Reset suppresses every side-effecting enable in the same cycle it is asserted.
    assign pc_en       = pc_en_s & ~rst;
    assign ir_write    = ir_write_s & ~rst;
    assign mem_read    = mem_read_s & ~rst;
    assign mem_write   = mem_write_s & ~rst;
    assign reg_write   = reg_write_s & ~rst;
    assign iord        = iord_s;
    assign reg_dst     = reg_dst_s;
    assign mem2reg     = mem2reg_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign pc_src      = pc_src_s;
    assign alu_control = alu_control_s;
    assign state       = state_r;
    assign instr_count = instr_count_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction
// streams checked against a per-instruction state-path model.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          zero, mem_ready;
    logic          pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem2reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, pc_src, err_code;
    logic [2:0]    alu_control;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad = 0;
    int model_count = 0;

    multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control), .state(state),
        .instr_count(instr_count), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    const logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    const logic [5:0] class_op [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    // Control table: {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem2reg,reg_write,src_a,src_b,pc_src,alu}
    function automatic logic [15:0] ref_ctl(input int s, input logic r, input logic z, input logic [5:0] f);
        logic pe = 1'b0, io = 1'b0, mr = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0, m2r = 1'b0, rw = 1'b0, sa = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (s)
            0:  begin pe = r; irw = r; mr = 1'b1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin io = 1'b1; mr = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; alu = ref_alu(f); end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pe = z; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pe = 1'b1; end
            default: pe = 1'b0;
        endcase
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu};
    endfunction

    // Drives one instruction from FETCH with given memory latencies and checks every cycle.
    task automatic run_instr(input int cls, input logic [5:0] fn, input logic z, input int fw, input int mw);
        int st_q[$];
        logic rdy_q[$];
        logic [15:0] obs, expv;
        for (int i = 0; i <= fw; i++) begin st_q.push_back(0); rdy_q.push_back(i == fw); end
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        case (cls)
            0: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i <= mw; i++) begin st_q.push_back(3); rdy_q.push_back(i == mw); end
                st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1)));
            end
            1: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i <= mw; i++) begin st_q.push_back(5); rdy_q.push_back(i == mw); end
            end
            2: begin st_q.push_back(6); st_q.push_back(7); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1); end
            3: begin st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1))); end
            4: begin st_q.push_back(9); st_q.push_back(10); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); end
            default: begin st_q.push_back(11); rdy_q.push_back(1'($urandom_range(0, 1))); end
        endcase
        opcode = class_op[cls];
        funct  = fn;
        zero   = z;
        foreach (st_q[k]) begin
            mem_ready = rdy_q[k];
            #1;
            obs  = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem2reg, reg_write,
                    alu_src_a, alu_src_b, pc_src, alu_control};
            expv = ref_ctl(st_q[k], rdy_q[k], z, fn);
            total++;
            if ({state, obs} !== {4'(st_q[k]), expv}) begin
                bad++;
                $display("FAIL rand_cycle cls=%0d step=%0d: state/ctl got %0d/%h expected %0d/%h",
                         cls, k, state, obs, st_q[k], expv);
            end
            tick();
        end
        model_count = (model_count + 1) % (1 << CW);
        total++;
        if (instr_count !== CW'(model_count)) begin
            bad++;
            $display("FAIL rand_count: got %0d expected %0d", instr_count, model_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b000010; funct = 6'b000000;
        tick(); tick(); #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        total++; if (instr_count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err: got %0d expected 0", err_code); end
        total++;
        if ({pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b00000) begin
            bad++; $display("FAIL reset_enables: got %b expected 00000", {pc_en, ir_write, mem_read, mem_write, reg_write});
        end
        rst = 1'b0;
        model_count = 0;
    endtask

    task automatic test_add();
        int exp_s [5] = '{0, 1, 6, 7, 0};
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (state !== 4'(exp_s[i])) begin bad++; $display("FAIL add_path[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
            if (i == 3) begin
                total++;
                if ({reg_write, reg_dst} !== 2'b11) begin bad++; $display("FAIL add_aluwb: got %b expected 11", {reg_write, reg_dst}); end
            end
            if (i < 4) tick();
        end
        model_count = model_count + 1;
        total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL add_count: got %0d expected %0d", instr_count, model_count); end
    endtask

    task automatic test_lw_wait();
        opcode = 6'b100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            total++;
            if ({state, mem_read, iord} !== {4'd3, 1'b1, 1'b1}) begin
                bad++; $display("FAIL lw_memrd[%0d]: got st=%0d rd=%b iord=%b expected st=3 rd=1 iord=1", i, state, mem_read, iord);
            end
            tick();
        end
        #1;
        total++;
        if ({state, mem2reg, reg_write} !== {4'd4, 1'b1, 1'b1}) begin
            bad++; $display("FAIL lw_memwb: got st=%0d m2r=%b rw=%b expected st=4 m2r=1 rw=1", state, mem2reg, reg_write);
        end
        tick();
        model_count = (model_count + 1) % (1 << CW);
        total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL lw_count: got %0d expected %0d", instr_count, model_count); end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100; zero = 1'(z); mem_ready = 1'b1;
            tick(); tick(); #1;
            total++;
            if ({state, pc_en, pc_src} !== {4'd8, 1'(z), 2'b01}) begin
                bad++; $display("FAIL beq_z%0d: got st=%0d pc_en=%b pc_src=%b expected st=8 pc_en=%0d pc_src=01", z, state, pc_en, pc_src, z);
            end
            tick();
            model_count = (model_count + 1) % (1 << CW);
            total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL beq_count_z%0d: got %0d expected %0d", z, instr_count, model_count); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_instr(int'($urandom_range(0, 5)), legal_fn[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        int exp_cyc [6] = '{5, 4, 4, 3, 4, 3};
        int n;
        for (int c = 0; c < 6; c++) begin
            opcode = class_op[c]; funct = legal_fn[$urandom_range(0, 4)];
            zero = 1'($urandom_range(0, 1)); mem_ready = 1'b1;
            n = 0;
            do begin tick(); n++; end while (state !== 4'd0 && n < 12);
            total++; if (n != exp_cyc[c]) begin bad++; $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", c, n, exp_cyc[c]); end
            model_count = (model_count + 1) % (1 << CW);
            total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", c, instr_count, model_count); end
        end
    endtask

    task automatic test_trap();
        opcode = 6'b111111; mem_ready = 1'b1;
        tick(); tick(); #1;
        total++;
        if ({state, err_code} !== {4'd12, 2'b01}) begin bad++; $display("FAIL trap_entry: got st=%0d err=%0d expected st=12 err=1", state, err_code); end
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1)); opcode = 6'($urandom);
            #1;
            total++;
            if ({state, err_code, pc_en, ir_write, mem_read, mem_write, reg_write} !== {4'd12, 2'b01, 5'b00000}) begin
                bad++; $display("FAIL trap_hold[%0d]: got st=%0d err=%0d en=%b expected st=12 err=1 en=00000", i, state, err_code,
                                {pc_en, ir_write, mem_read, mem_write, reg_write});
            end
            tick();
        end
        total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL trap_count: got %0d expected %0d", instr_count, model_count); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        model_count = 0;
        total++;
        if ({state, err_code} !== {4'd0, 2'b00}) begin bad++; $display("FAIL trap_reset: got st=%0d err=%0d expected st=0 err=0", state, err_code); end
    endtask

    task automatic test_timeout();
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        #1;
        total++;
        if ({state, err_code} !== {4'd12, 2'b11}) begin bad++; $display("FAIL timeout_trap: got st=%0d err=%0d expected st=12 err=3", state, err_code); end
        rst = 1'b1; tick(); rst = 1'b0;
        model_count = 0;
        for (int rep = 0; rep < 2; rep++) begin
            mem_ready = 1'b0;
            for (int i = 0; i < 15; i++) tick();
            mem_ready = 1'b1;
            tick(); #1;
            total++;
            if ({state, err_code} !== {4'd1, 2'b00}) begin bad++; $display("FAIL timeout_ready_wins[%0d]: got st=%0d err=%0d expected st=1 err=0", rep, state, err_code); end
            tick(); tick(); tick();
            model_count = model_count + 1;
            total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL timeout_count[%0d]: got %0d expected %0d", rep, instr_count, model_count); end
        end
    endtask

    task automatic test_wrap_and_rst();
        rst = 1'b1; tick(); rst = 1'b0;
        model_count = 0;
        opcode = 6'b000010; mem_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            tick(); tick(); #1;
            total++;
            if ({state, pc_en, pc_src} !== {4'd11, 1'b1, 2'b10}) begin
                bad++; $display("FAIL jump[%0d]: got st=%0d pc_en=%b pc_src=%b expected st=11 pc_en=1 pc_src=10", j, state, pc_en, pc_src);
            end
            tick();
            model_count = (model_count + 1) % (1 << CW);
        end
        total++; if (instr_count !== CW'(model_count)) begin bad++; $display("FAIL wrap_count: got %0d expected %0d", instr_count, model_count); end
        opcode = 6'b101011;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        total++; if ({state, mem_write} !== {4'd5, 1'b1}) begin bad++; $display("FAIL sw_memwr: got st=%0d mw=%b expected st=5 mw=1", state, mem_write); end
        rst = 1'b1; mem_ready = 1'b1; #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_memwr_gate: got %b expected 0", mem_write); end
        tick(); rst = 1'b0; #1;
        model_count = 0;
        total++;
        if ({state, instr_count} !== {4'd0, CW'(model_count)}) begin
            bad++; $display("FAIL rst_mid_instr: got st=%0d cnt=%0d expected st=0 cnt=0", state, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_random();
        test_back_to_back();
        test_trap();
        test_timeout();
        test_wrap_and_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
